// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-beat accumulator: folds up to five masked operands per beat
// plus the redundant accumulator through a 7:3 tree and resolves on the last beat.
// Build option: define CSA_ACC_SIGNED_EN to sign-extend lanes (default zero-extends).

module tree_7_3 #(
  parameter int MAX = 24
) (
  input  logic [MAX-1:0] op [7],
  output logic [MAX-1:0] sum,
  output logic [MAX-1:0] carry
);

  // One full-adder row; the carry is pre-shifted and its MSB falls off,
  // which keeps every intermediate vector modulo 2^MAX.
  function automatic logic [2*MAX-1:0] csa(input logic [MAX-1:0] a,
                                            input logic [MAX-1:0] b,
                                            input logic [MAX-1:0] c);
    logic [MAX-1:0] s;
    logic [MAX-1:0] k;
    s = a ^ b ^ c;
    k = ((a & b) | (a & c) | (b & c)) << 1;
    return {s, k};
  endfunction

  logic [MAX-1:0] s1, c1, s2, c2, s3, c3, s4, c4;

  always_comb begin
    // NOTE: blocking assignments are correct here: this is combinational
    // logic and each line consumes the value computed on the line before.
    {s1, c1}     = csa(op[0], op[1], op[2]);
    {s2, c2}     = csa(op[3], op[4], op[5]);
    {s3, c3}     = csa(s1, c1, s2);
    {s4, c4}     = csa(s3, c3, c2);
    {sum, carry} = csa(s4, c4, op[6]);
  end

endmodule

module csa_accum_ctrl #(
  parameter int W  = 16,
  parameter int AW = 24,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*W-1:0]  in_data,
  input  logic [4:0]      in_mask,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_sum,
  output logic [CW-1:0]   out_cnt
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] acc_s, acc_c;
  logic [CW-1:0] cnt;

  logic accept;
  logic load_result;
  logic clear_acc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ACCUM:   if (in_valid && in_last) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    accept      = 1'b0;
    load_result = 1'b0;
    clear_acc   = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      RESOLVE: load_result = 1'b1;
      OUT:     clear_acc   = out_ready;
      default: ;
    endcase
  end

  // ------------------------------------------------------- lane operands
  logic [AW-1:0] tree_op [7];
  logic [AW-1:0] tree_s, tree_c;
  logic [2:0]    pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < 5; k++) begin
      if (in_mask[k]) begin
`ifdef CSA_ACC_SIGNED_EN
        tree_op[k] = AW'($signed(in_data[k*W +: W]));
`else
        tree_op[k] = AW'(in_data[k*W +: W]);
`endif
        pop = pop + 3'd1;
      end else begin
        tree_op[k] = '0;
      end
    end
    tree_op[5] = acc_s;
    tree_op[6] = acc_c;
  end

  tree_7_3 #(.MAX(AW)) u_tree (
    .op    (tree_op),
    .sum   (tree_s),
    .carry (tree_c)
  );

  // Count is widened by one bit so the overflow into the top bit flags saturation.
  logic [CW:0]   cnt_wide;
  logic [CW-1:0] cnt_sat;

  always_comb begin
    cnt_wide = {1'b0, cnt} + (CW+1)'(pop);
    cnt_sat  = cnt_wide[CW] ? {CW{1'b1}} : cnt_wide[CW-1:0];
  end

  // ----------------------------------------------------------- datapath
  // NOTE: all state is sequential and uses <=; every register here is a
  // small flop (no memory arrays), so all of it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s <= '0;
      acc_c <= '0;
      cnt   <= '0;
    end else if (accept) begin
      acc_s <= tree_s;
      acc_c <= tree_c;
      cnt   <= cnt_sat;
    end else if (clear_acc) begin
      acc_s <= '0;
      acc_c <= '0;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
    end else if (load_result) begin
      out_valid <= 1'b1;
      out_sum   <= acc_s + acc_c;
      out_cnt   <= cnt;
    end else if (clear_acc) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed self-checking bench for csa_accum_ctrl (W=16, AW=24, CW=8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_csa_accum_ctrl;

  localparam int W  = 16;
  localparam int AW = 24;
  localparam int CW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [5*W-1:0]  in_data;
  logic [4:0]      in_mask;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sum;
  logic [CW-1:0]   out_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  csa_accum_ctrl #(.W(W), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5*W-1:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                           input logic [15:0] l2, input logic [15:0] l3,
                                           input logic [15:0] l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // Present one beat for exactly one rising edge; returns at the next falling edge.
  task automatic send_beat(input logic [5*W-1:0] d, input logic [4:0] m, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
    in_mask  = 5'($urandom());
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [AW-1:0] exp_ffff5;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   32'(out_sum), 32'd0);
    check("rst_out_cnt",   32'(out_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat 1..5, latency: RESOLVE after acceptance edge, valid after the next
    send_beat(lanes(16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 5'b11111, 1'b1);
    check("t1_resolve_ready", {31'd0, in_ready}, 32'd0);
    check("t1_resolve_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sum", 32'(out_sum), 32'd15);
    check("t1_cnt", 32'(out_cnt), 32'd5);
    consume("t1");

    // Masked lanes, carry across the lane width
    send_beat(lanes(16'hFFFF, 16'h1234, 16'h0001, 16'h1234, 16'h1234), 5'b00101, 1'b1);
    wait_result("t2");
    check("t2_sum", 32'(out_sum), 32'h010000);
    check("t2_cnt", 32'(out_cnt), 32'd2);
    consume("t2");

    // Three back-to-back beats of all-ones lanes
    send_beat(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 5'b11111, 1'b0);
    check("t3_ready_b1", {31'd0, in_ready}, 32'd1);
    send_beat(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 5'b11111, 1'b0);
    check("t3_ready_b2", {31'd0, in_ready}, 32'd1);
    send_beat(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 5'b11111, 1'b1);
    wait_result("t3");
    check("t3_sum", 32'(out_sum), 32'h0EFFF1);
    check("t3_cnt", 32'(out_cnt), 32'd15);
    consume("t3");

    // Output stall with a pending beat held on the input
    send_beat(lanes(16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 5'b11111, 1'b1);
    in_valid = 1'b1;
    in_data  = lanes(16'd2, 16'd7, 16'd7, 16'd7, 16'd7);
    in_mask  = 5'b00001;
    in_last  = 1'b1;
    wait_result("t4");
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t4_stall_sum",   32'(out_sum), 32'd15);
      check("t4_stall_cnt",   32'(out_cnt), 32'd5);
      check("t4_stall_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_ready_after_hs", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_accepted", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("t4b_valid", {31'd0, out_valid}, 32'd1);
    check("t4b_sum", 32'(out_sum), 32'd2);
    check("t4b_cnt", 32'(out_cnt), 32'd1);
    consume("t4b");

    // Five all-ones lanes: extension mode decides the result
`ifdef CSA_ACC_SIGNED_EN
    exp_ffff5 = 24'hFFFFFB;
`else
    exp_ffff5 = 24'h04FFFB;
`endif
    send_beat(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 5'b11111, 1'b1);
    wait_result("t5");
    check("t5_sum", 32'(out_sum), 32'(exp_ffff5));
    check("t5_cnt", 32'(out_cnt), 32'd5);
    consume("t5");

    // Empty burst
    send_beat(lanes(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555), 5'b00000, 1'b1);
    wait_result("t6");
    check("t6_sum", 32'(out_sum), 32'd0);
    check("t6_cnt", 32'(out_cnt), 32'd0);
    consume("t6");

    // Idle cycles (in_valid=0, random data) hold the accumulator
    send_beat(lanes(16'd10, 16'd0, 16'd0, 16'd0, 16'd0), 5'b00001, 1'b0);
    repeat (3) @(negedge clk);
    check("t7_idle_ready", {31'd0, in_ready}, 32'd1);
    send_beat(lanes(16'd0, 16'd5, 16'd0, 16'd0, 16'd0), 5'b00010, 1'b1);
    wait_result("t7");
    check("t7_sum", 32'(out_sum), 32'd15);
    check("t7_cnt", 32'(out_cnt), 32'd2);
    consume("t7");

    // Count saturation: 52 beats x 5 lanes = 260 operands
    for (int i = 0; i < 52; i++)
      send_beat(lanes(16'd1, 16'd1, 16'd1, 16'd1, 16'd1), 5'b11111, (i == 51));
    wait_result("t8");
    check("t8_sum", 32'(out_sum), 32'd260);
    check("t8_cnt", 32'(out_cnt), 32'd255);
    consume("t8");

    // Reset mid-burst discards accumulated state
    send_beat(lanes(16'd100, 16'd100, 16'd100, 16'd100, 16'd100), 5'b11111, 1'b0);
    send_beat(lanes(16'd100, 16'd100, 16'd100, 16'd100, 16'd100), 5'b11111, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t9_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t9_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t9_rst_sum",   32'(out_sum), 32'd0);
    check("t9_rst_cnt",   32'(out_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(lanes(16'd1, 16'd1, 16'd1, 16'd1, 16'd1), 5'b11111, 1'b1);
    wait_result("t9");
    check("t9_sum", 32'(out_sum), 32'd5);
    check("t9_cnt", 32'(out_cnt), 32'd5);
    consume("t9");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
